// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter: FSM states,
// access-size codes and the alignment rule applied at grant time.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] OPT_BYTE = 2'b00;
  localparam logic [1:0] OPT_HALF = 2'b01;
  localparam logic [1:0] OPT_WORD = 2'b10;

  // Codes 10 and 11 are both word accesses, so anything not byte/half is a word.
  function automatic logic is_misaligned(input logic [1:0] opt, input logic [1:0] addr_lo);
    case (opt)
      OPT_BYTE: is_misaligned = 1'b0;
      OPT_HALF: is_misaligned = addr_lo[0];
      default:  is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_pick2.sv
// Combinational two-requester winner select; prio only matters on a tie and
// only when round-robin mode is enabled.
module memory_arbiter_rr_pick2 #(
  parameter logic ROUND_ROBIN = 1'b1
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_prio,
  output logic o_valid,
  output logic o_winner
);

  // Tie-break on prio or fixed port 0; otherwise the single requester wins.
  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_winner = ROUND_ROBIN ? i_prio : 1'b0;
    end else begin
      o_winner = i_req1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one combinational-read memory between fetch (port 0) and load/store
// (port 1), one access at a time through IDLE -> ACCESS -> DONE.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter logic ROUND_ROBIN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_req,
  input  logic        i_p1_req,
  input  logic        i_p0_write,
  input  logic        i_p1_write,
  input  logic [1:0]  i_p0_option,
  input  logic [1:0]  i_p1_option,
  input  logic [31:0] i_p0_address,
  input  logic [31:0] i_p1_address,
  input  logic [31:0] i_p0_write_data,
  input  logic [31:0] i_p1_write_data,
  output logic        o_p0_ack,
  output logic        o_p1_ack,
  output logic        o_p0_err,
  output logic        o_p1_err,
  output logic [31:0] o_p0_read_data,
  output logic [31:0] o_p1_read_data,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [1:0]  o_mem_option,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  input  logic [31:0] i_mem_read_data
);

  state_t      r_state;
  logic        r_prio;
  logic        r_win;
  logic        r_misal;
  logic        r_p0_ack, r_p1_ack, r_p0_err, r_p1_err;
  logic [31:0] r_p0_rdata, r_p1_rdata;
  logic        r_mem_read, r_mem_write;
  logic [1:0]  r_mem_option;
  logic [31:0] r_mem_address, r_mem_wdata;

  logic        w_grant_valid;
  logic        w_winner;
  logic        w_sel_write;
  logic [1:0]  w_sel_option;
  logic [31:0] w_sel_address;
  logic [31:0] w_sel_wdata;
  logic        w_sel_misal;

  memory_arbiter_rr_pick2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .i_req0   (i_p0_req),
    .i_req1   (i_p1_req),
    .i_prio   (r_prio),
    .o_valid  (w_grant_valid),
    .o_winner (w_winner)
  );

  assign w_sel_write   = w_winner ? i_p1_write      : i_p0_write;
  assign w_sel_option  = w_winner ? i_p1_option     : i_p0_option;
  assign w_sel_address = w_winner ? i_p1_address    : i_p0_address;
  assign w_sel_wdata   = w_winner ? i_p1_write_data : i_p0_write_data;
  assign w_sel_misal   = is_misaligned(w_sel_option, w_sel_address[1:0]);

  // Arbiter FSM; the mem_* bus is loaded at grant so it is valid for exactly the ACCESS cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_prio        <= 1'b0;
      r_win         <= 1'b0;
      r_misal       <= 1'b0;
      r_p0_ack      <= 1'b0;
      r_p1_ack      <= 1'b0;
      r_p0_err      <= 1'b0;
      r_p1_err      <= 1'b0;
      r_p0_rdata    <= 32'd0;
      r_p1_rdata    <= 32'd0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_option  <= 2'b00;
      r_mem_address <= 32'd0;
      r_mem_wdata   <= 32'd0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      r_p0_err <= 1'b0;
      r_p1_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_win         <= w_winner;
            r_misal       <= w_sel_misal;
            r_mem_read    <= ~w_sel_write & ~w_sel_misal;
            r_mem_write   <= w_sel_write & ~w_sel_misal;
            r_mem_option  <= w_sel_misal ? 2'b00 : w_sel_option;
            r_mem_address <= w_sel_misal ? 32'd0 : w_sel_address;
            r_mem_wdata   <= w_sel_misal ? 32'd0 : w_sel_wdata;
            r_state       <= ST_ACCESS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          r_mem_read    <= 1'b0;
          r_mem_write   <= 1'b0;
          r_mem_option  <= 2'b00;
          r_mem_address <= 32'd0;
          r_mem_wdata   <= 32'd0;
          // Stores and rejected accesses return zero so stale load data never lingers.
          if (r_win) begin
            r_p1_ack   <= 1'b1;
            r_p1_err   <= r_misal;
            r_p1_rdata <= r_mem_read ? i_mem_read_data : 32'd0;
          end else begin
            r_p0_ack   <= 1'b1;
            r_p0_err   <= r_misal;
            r_p0_rdata <= r_mem_read ? i_mem_read_data : 32'd0;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_prio  <= ~r_win;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_p0_ack         = r_p0_ack;
  assign o_p1_ack         = r_p1_ack;
  assign o_p0_err         = r_p0_err;
  assign o_p1_err         = r_p1_err;
  assign o_p0_read_data   = r_p0_rdata;
  assign o_p1_read_data   = r_p1_rdata;
  assign o_mem_read       = r_mem_read;
  assign o_mem_write      = r_mem_write;
  assign o_mem_option     = r_mem_option;
  assign o_mem_address    = r_mem_address;
  assign o_mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a round-robin instance on a byte memory
// model with an ack scoreboard, plus a fixed-priority instance for grant order.
module tb_memory_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_init;
  logic        p0_req, p1_req, p0_write, p1_write;
  logic [1:0]  p0_opt, p1_opt;
  logic [31:0] p0_addr, p1_addr, p0_wd, p1_wd;
  logic        p0_ack, p1_ack, p0_err, p1_err;
  logic [31:0] p0_rd, p1_rd;
  logic        mem_read, mem_write;
  logic [1:0]  mem_opt;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        fp_p0_ack, fp_p1_ack, fp_p0_err, fp_p1_err;
  logic [31:0] fp_p0_rd, fp_p1_rd;
  logic        fp_mem_read, fp_mem_write;
  logic [1:0]  fp_mem_opt;
  logic [31:0] fp_mem_addr, fp_mem_wd;

  memory_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_p0_req(p0_req), .i_p1_req(p1_req), .i_p0_write(p0_write), .i_p1_write(p1_write),
    .i_p0_option(p0_opt), .i_p1_option(p1_opt), .i_p0_address(p0_addr), .i_p1_address(p1_addr),
    .i_p0_write_data(p0_wd), .i_p1_write_data(p1_wd),
    .o_p0_ack(p0_ack), .o_p1_ack(p1_ack), .o_p0_err(p0_err), .o_p1_err(p1_err),
    .o_p0_read_data(p0_rd), .o_p1_read_data(p1_rd),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_option(mem_opt),
    .o_mem_address(mem_addr), .o_mem_write_data(mem_wd), .i_mem_read_data(mem_rd)
  );

  memory_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .i_clk(clk), .i_reset(reset),
    .i_p0_req(p0_req), .i_p1_req(p1_req), .i_p0_write(p0_write), .i_p1_write(p1_write),
    .i_p0_option(p0_opt), .i_p1_option(p1_opt), .i_p0_address(p0_addr), .i_p1_address(p1_addr),
    .i_p0_write_data(p0_wd), .i_p1_write_data(p1_wd),
    .o_p0_ack(fp_p0_ack), .o_p1_ack(fp_p1_ack), .o_p0_err(fp_p0_err), .o_p1_err(fp_p1_err),
    .o_p0_read_data(fp_p0_rd), .o_p1_read_data(fp_p1_rd),
    .o_mem_read(fp_mem_read), .o_mem_write(fp_mem_write), .o_mem_option(fp_mem_opt),
    .o_mem_address(fp_mem_addr), .o_mem_write_data(fp_mem_wd), .i_mem_read_data(fp_mem_addr)
  );

  // Byte-addressed memory model: combinational size-masked read, write on clock edge.
  logic [7:0] mem [0:255];
  logic [7:0] ma8;
  assign ma8 = mem_addr[7:0];

  always_comb begin
    mem_rd = {mem[ma8 + 8'd3], mem[ma8 + 8'd2], mem[ma8 + 8'd1], mem[ma8]};
    case (mem_opt)
      2'b00:   mem_rd = mem_rd & 32'h0000_00FF;
      2'b01:   mem_rd = mem_rd & 32'h0000_FFFF;
      default: mem_rd = mem_rd;
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hEF; mem[8'h11] <= 8'hBE; mem[8'h12] <= 8'hAD; mem[8'h13] <= 8'hDE;
      mem[8'h20] <= 8'h78; mem[8'h21] <= 8'h56; mem[8'h22] <= 8'hFE; mem[8'h23] <= 8'hCA;
      mem[8'h40] <= 8'h44; mem[8'h41] <= 8'h33; mem[8'h42] <= 8'h22; mem[8'h43] <= 8'h11;
    end else if (mem_write) begin
      mem[ma8] <= mem_wd[7:0];
      if (mem_opt != 2'b00) mem[ma8 + 8'd1] <= mem_wd[15:8];
      if (mem_opt[1]) begin
        mem[ma8 + 8'd2] <= mem_wd[23:16];
        mem[ma8 + 8'd3] <= mem_wd[31:24];
      end
    end
  end

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic err, input logic [31:0] rdata);
    exp_q.push_back({port, err, rdata});
  endtask

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (p0_ack || p1_ack) begin
      chk("exp_available", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("ack_port", 32'(p1_ack), 32'(mon_e.port));
        chk("single_ack", 32'(p0_ack & p1_ack), 32'd0);
        chk("ack_err", 32'(mon_e.port ? p1_err : p0_err), 32'(mon_e.err));
        chk("ack_rdata", mon_e.port ? p1_rd : p0_rd, mon_e.rdata);
      end
    end
  end

  // Waits (bounded) for the next ack, recording memory bus activity on the way.
  task automatic wait_ack(output int n_cyc, output int n_mem, output logic [31:0] m_addr,
                          output logic [31:0] m_wd);
    bit got;
    got = 1'b0; n_cyc = 0; n_mem = 0; m_addr = 32'd0; m_wd = 32'd0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      n_cyc++;
      if (mem_read || mem_write) begin
        n_mem++;
        m_addr = mem_addr;
        m_wd   = mem_wd;
      end
      if (p0_ack || p1_ack) got = 1'b1;
    end
    chk("ack_wait", 32'(got), 32'd1);
  endtask

  task automatic set_p0(input logic w, input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    p0_write = w; p0_opt = o; p0_addr = a; p0_wd = d; p0_req = 1'b1;
  endtask

  task automatic set_p1(input logic w, input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    p1_write = w; p1_opt = o; p1_addr = a; p1_wd = d; p1_req = 1'b1;
  endtask

  initial begin
    int          nc, nm;
    logic [31:0] ma, mw;
    reset = 1'b1; mem_init = 1'b1;
    set_p0(1'b0, 2'b10, 32'h10, 32'd0);
    set_p1(1'b0, 2'b10, 32'h40, 32'd0);

    // Reset held two cycles with both ports requesting.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      mem_init = 1'b0;
      chk("rst_ack", {30'd0, p0_ack, p1_ack}, 32'd0);
      chk("rst_err", {30'd0, p0_err, p1_err}, 32'd0);
      chk("rst_rd0", p0_rd, 32'd0);
      chk("rst_rd1", p1_rd, 32'd0);
      chk("rst_mem_ctl", {29'd0, mem_read, mem_write, 1'b0}, 32'd0);
      chk("rst_mem_bus", mem_addr | mem_wd | 32'(mem_opt), 32'd0);
    end
    reset = 1'b0;

    // Continuous contention: alternation on dut, port 0 every time on dut_fp.
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    push(1'b1, 1'b0, 32'h1122_3344);
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    push(1'b1, 1'b0, 32'h1122_3344);
    for (int k = 0; k < 4; k++) begin
      wait_ack(nc, nm, ma, mw);
      chk("cont_spacing", 32'(nc), 32'd3);
      chk("cont_mem_cycles", 32'(nm), 32'd1);
      chk("cont_addr", ma, (k % 2 == 1) ? 32'h40 : 32'h10);
      chk("fp_p0_ack", 32'(fp_p0_ack), 32'd1);
      chk("fp_p1_ack", 32'(fp_p1_ack), 32'd0);
      if (k == 3) begin
        p0_req = 1'b0; p1_req = 1'b0;
      end
    end

    // Halfword store then word load: only the low half changes.
    set_p1(1'b1, 2'b01, 32'h20, 32'hFFFF_1234);
    push(1'b1, 1'b0, 32'd0);
    wait_ack(nc, nm, ma, mw);
    chk("st_mem_cycles", 32'(nm), 32'd1);
    chk("st_addr", ma, 32'h20);
    chk("st_wdata", mw, 32'hFFFF_1234);
    set_p1(1'b0, 2'b10, 32'h20, 32'd0);
    push(1'b1, 1'b0, 32'hCAFE_1234);
    wait_ack(nc, nm, ma, mw);
    chk("ld_mem_cycles", 32'(nm), 32'd1);
    p1_req = 1'b0;
    set_p0(1'b0, 2'b00, 32'h21, 32'd0);
    push(1'b0, 1'b0, 32'h0000_0012);
    wait_ack(nc, nm, ma, mw);
    chk("byte_ld_mem_cycles", 32'(nm), 32'd1);

    // Misaligned word and halfword: error ack, no memory access, data cleared.
    p0_req = 1'b0;
    set_p1(1'b0, 2'b10, 32'h22, 32'd0);
    push(1'b1, 1'b1, 32'd0);
    wait_ack(nc, nm, ma, mw);
    chk("misal_w_mem_cycles", 32'(nm), 32'd0);
    p1_req = 1'b0;
    set_p0(1'b0, 2'b01, 32'h11, 32'd0);
    push(1'b0, 1'b1, 32'd0);
    wait_ack(nc, nm, ma, mw);
    chk("misal_h_mem_cycles", 32'(nm), 32'd0);
    p0_req = 1'b0;

    // Byte store with reset raised in its ACCESS cycle: write commits, no ack.
    set_p1(1'b1, 2'b00, 32'h30, 32'h0000_00AB);
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_acc_mem_write", 32'(mem_write), 32'd1);
    chk("rst_acc_addr", mem_addr, 32'h30);
    reset = 1'b1; p1_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_acc_no_ack", 32'(p1_ack), 32'd0);
    chk("rst_acc_bus_idle", 32'(mem_write), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_acc_no_late_ack", 32'(p1_ack), 32'd0);
    chk("rst_acc_rd1", p1_rd, 32'd0);
    set_p1(1'b0, 2'b10, 32'h30, 32'd0);
    push(1'b1, 1'b0, 32'h0000_00AB);
    wait_ack(nc, nm, ma, mw);
    chk("rst_acc_reload_spacing", 32'(nc), 32'd3);
    p1_req = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
